// File: rtl/soc_bram_lanes.sv
// soc_bram_lanes: byte-lane BRAM controller with sized, optionally unaligned, wrapping accesses
module soc_bram_lanes #(
  parameter int ADDR_WIDTH      = 10,
  parameter int LANES           = 4,
  parameter bit ALLOW_UNALIGNED = 1'b1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   valid,
  output logic                   ready,
  input  logic                   rw,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [1:0]             size,
  input  logic [8*LANES-1:0]     wdata,
  output logic [8*LANES-1:0]     rdata,
  output logic                   done,
  output logic                   fault
);
  localparam int LG = $clog2(LANES);
  localparam int WW = ADDR_WIDTH - LG;
  localparam int DEPTH = 1 << WW;
  localparam logic [2:0] LG3 = 3'(LG);
  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0] size_q, size_d;
  logic rw_q, rw_d, flt_q, flt_d, done_q, done_d, fault_q, fault_d;
  logic [8*LANES-1:0] wdata_q, wdata_d, rdata_q, rdata_d, dout, rd_asm;
  logic [LG-1:0] off;
  logic [WW-1:0] word;
  logic [3:0] n, n_in;
  logic req_flt, accept;
  assign off = addr_q[LG-1:0];
  assign word = addr_q[ADDR_WIDTH-1:LG];
  assign n = 4'd1 << size_q;
  assign n_in = 4'd1 << size;
  assign req_flt = ({1'b0, size} > LG3) || (!ALLOW_UNALIGNED && |(addr[3:0] & (n_in - 4'd1)));
  assign ready = state_q == IDLE;
  assign accept = valid && ready;
  assign rdata = rdata_q;
  assign done = done_q;
  assign fault = fault_q;
  // Lanes below the start offset belong to the following word (wrapping at the top).
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [LG-1:0] rel;
    logic [WW-1:0] baddr;
    logic we;
    logic [7:0] dq;
    assign rel = LG'(i) - off;
    assign baddr = (LG'(i) < off) ? word + WW'(1) : word;
    assign we = (state_q == ACCESS) && rw_q && !flt_q && (4'(rel) < n);
    always_ff @(posedge clk) begin
      if (we && rstn) mem[baddr] <= wdata_q[{rel, 3'b000} +: 8];
      dq <= mem[baddr];
    end
    assign dout[8*i +: 8] = dq;
  end
  always_comb begin
    rd_asm = '0;
    for (int k = 0; k < LANES; k++)
      rd_asm[8*k +: 8] = (4'(k) < n) ? dout[{off + LG'(k), 3'b000} +: 8] : 8'd0;
  end
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    size_d = size_q;
    rw_d = rw_q;
    wdata_d = wdata_q;
    flt_d = flt_q;
    rdata_d = rdata_q;
    done_d = state_q == RESP;
    fault_d = (state_q == RESP) && flt_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = ACCESS;
        addr_d = addr;
        size_d = size;
        rw_d = rw;
        wdata_d = wdata;
        flt_d = req_flt;
      end
      ACCESS: state_d = CAPTURE;
      CAPTURE: begin
        state_d = RESP;
        rdata_d = flt_q ? '0 : (rw_q ? rdata_q : rd_asm);
      end
      RESP: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q <= '0;
      size_q <= '0;
      rw_q <= 1'b0;
      wdata_q <= '0;
      flt_q <= 1'b0;
      rdata_q <= '0;
      done_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      size_q <= size_d;
      rw_q <= rw_d;
      wdata_q <= wdata_d;
      flt_q <= flt_d;
      rdata_q <= rdata_d;
      done_q <= done_d;
      fault_q <= fault_d;
    end
  end
endmodule
